// File: rtl/eight_bit_sequential_divider_pkg.sv
// Shared types and sizing for the sequential divider.
// Zero-divisor shortcut is enabled by defining DIVIDER_ZERO_CHECK_EN.
package divider_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/eight_bit_sequential_divider_subtractor.sv
// Combinational borrow look-ahead subtractor: diff = a - b.
// Each bit is a look-ahead unit chained through the borrow.
module borrow_look_ahead_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N-1:0] prop;
  logic [N-1:0] gen;
  logic         br;

  assign prop = ~(a ^ b);
  assign gen  = ~a & b;

  always_comb begin
    br   = 1'b0;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff[i] = ~prop[i] ^ br;
      br      = gen[i] | (prop[i] & br);
    end
    borrow_out = br;
  end

endmodule

// File: rtl/eight_bit_sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_ZERO_CHECK_EN to finish zero divisors right after accept.
module eight_bit_sequential_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sub_a;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic             last;
  logic             zero_skip;

  assign sub_a = {rem, q[WIDTH-1]};
  assign sub_b = {1'b0, dvsr};

  borrow_look_ahead_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a          (sub_a),
    .b          (sub_b),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // rem < divisor keeps a good difference below 2^WIDTH
  assign fits     = ~borrow & ~trial[WIDTH];
  assign rem_next = fits ? trial[WIDTH-1:0]
                         : sub_a[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], fits};
  assign last     = (count == CW'(1));

`ifdef DIVIDER_ZERO_CHECK_EN
  logic dbz;

  assign zero_skip = (divisor == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz <= 1'b0;
    end else if (state == IDLE && start) begin
      if (zero_skip) dbz <= 1'b1;
    end else if (state == RUN && last) begin
      dbz <= 1'b0;
    end
  end

  assign div_by_zero = dbz;
`else
  assign zero_skip   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = zero_skip ? DONE : RUN;
      RUN:  if (last)  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= '0;
      q         <= '0;
      dvsr      <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem   <= '0;
            q     <= dividend;
            dvsr  <= divisor;
            count <= CW'(WIDTH);
            if (zero_skip) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        RUN: begin
          rem   <= rem_next;
          q     <= q_next;
          count <= count - CW'(1);
          if (last) begin
            quotient  <= q_next;
            remainder <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_sequential_divider.sv
// Directed-vector and random-sample bench for the sequential divider.
// Expected zero-divisor behaviour follows DIVIDER_ZERO_CHECK_EN.
module tb_eight_bit_sequential_divider;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t tbl[12];

  eight_bit_sequential_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // lat = edges after the accepting edge until done is seen
  task automatic run_div(input string nm,
                         input logic [7:0] dd, input logic [7:0] dv,
                         input logic [7:0] eq, input logic [7:0] er);
    int   k;
    bit   busy_ok;
    bit   zs;
    zs = ZC && (dv == 8'd0);
    @(negedge clk);
    check({nm, ".idle_busy"}, int'(busy), 0);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~dd;
    divisor  = dv + 8'd3;
    k        = 0;
    busy_ok  = 1'b1;
    while (!done && k < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    check({nm, ".lat"}, k, zs ? 0 : 8);
    check({nm, ".busy_run"}, int'(busy_ok), 1);
    check({nm, ".busy_done"}, int'(busy), 0);
    check({nm, ".q"}, int'(quotient), int'(eq));
    check({nm, ".r"}, int'(remainder), int'(er));
    check({nm, ".dbz"}, int'(div_by_zero), int'(zs));
    @(posedge clk);
    #1;
    check({nm, ".done_drop"}, int'(done), 0);
    check({nm, ".q_hold"}, int'(quotient), int'(eq));
    check({nm, ".r_hold"}, int'(remainder), int'(er));
  endtask

  initial begin
    int         k;
    bit         seen;
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] eq;
    logic [7:0] er;

    tbl[0]  = '{8'd200, 8'd7,   8'd28,  8'd4};
    tbl[1]  = '{8'd255, 8'd1,   8'd255, 8'd0};
    tbl[2]  = '{8'd5,   8'd9,   8'd0,   8'd5};
    tbl[3]  = '{8'd100, 8'd0,   8'd255, 8'd100};
    tbl[4]  = '{8'd0,   8'd5,   8'd0,   8'd0};
    tbl[5]  = '{8'd255, 8'd255, 8'd1,   8'd0};
    tbl[6]  = '{8'd128, 8'd3,   8'd42,  8'd2};
    tbl[7]  = '{8'd9,   8'd2,   8'd4,   8'd1};
    tbl[8]  = '{8'd50,  8'd5,   8'd10,  8'd0};
    tbl[9]  = '{8'd254, 8'd16,  8'd15,  8'd14};
    tbl[10] = '{8'd1,   8'd255, 8'd0,   8'd1};
    tbl[11] = '{8'd0,   8'd0,   8'd255, 8'd0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.q", int'(quotient), 0);
    check("rst.r", int'(remainder), 0);
    check("rst.dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_div($sformatf("vec%0d", i), tbl[i].dd, tbl[i].dv,
              tbl[i].q, tbl[i].r);

    // second start while busy, then start held through the done cycle
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ovl.done_seen", int'(done), 1);
    check("ovl.q", int'(quotient), 28);
    check("ovl.r", int'(remainder), 4);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("ovl.done_start_ignored", int'(busy), 0);
    check("ovl.single_done", int'(done), 0);
    check("ovl.q_hold", int'(quotient), 28);
    start = 1'b0;
    run_div("b2b", 8'd50, 8'd5, 8'd10, 8'd0);

    // reset in the middle of a run
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst.busy", int'(busy), 0);
    check("mid_rst.done", int'(done), 0);
    check("mid_rst.q", int'(quotient), 0);
    check("mid_rst.r", int'(remainder), 0);
    check("mid_rst.dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst.no_done", int'(seen), 0);
    run_div("post_rst", 8'd9, 8'd2, 8'd4, 8'd1);

    // random sample against a behavioural model
    for (int i = 0; i < 250; i++) begin
      dd = 8'($urandom_range(0, 255));
      dv = (i % 40 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (dv == 8'd0) begin
        eq = 8'hff;
        er = dd;
      end else begin
        eq = dd / dv;
        er = dd % dv;
      end
      run_div($sformatf("rnd%0d_%0d_%0d", i, dd, dv), dd, dv, eq, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
